// File: rtl/zone_pkg.sv
// Shared definitions for the zone stages: state encoding, zone-ID width
// derivation and a single-bit-set test used to flag the last beat of a mask.
package zone_pkg;

    localparam int ZONE_MAX_W = 256;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } zone_state_t;

    // clog2 with a floor of 1 so a two-zone (or single-zone) build still has an ID bit.
    function automatic int zone_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic popcount_is_one(input logic [ZONE_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ZONE_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/zone_mask_serializer_ffs_encoder.sv
// Lowest-set-bit index encoder with an any-set flag; shared by the zone stages.
module ffs_encoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = zone_pkg::zone_id_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scanning downward lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule

// File: rtl/zone_mask_serializer.sv
// Serializes a zone mask into one zone-ID beat per set bit, lowest first,
// refilling on the last beat without a bubble and counting all-zero masks.
`ifndef CFG_ZONE_NUM
`define CFG_ZONE_NUM 16
`endif
`ifndef CFG_LIB_VEC_NUM
`define CFG_LIB_VEC_NUM 64
`endif

module zone_mask_serializer
    import zone_pkg::*;
#(
    parameter int ZONE_NUM   = `CFG_ZONE_NUM,
    parameter int ZONE_ID_W  = zone_id_width(ZONE_NUM),
    parameter int TAG_W      = $clog2(`CFG_LIB_VEC_NUM),
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ZONE_NUM-1:0]   zone_mask,
    input  logic [TAG_W-1:0]      mask_tag,
    input  logic                  mask_valid,
    output logic                  mask_ready,
    output logic [ZONE_ID_W-1:0]  zone_id,
    output logic [TAG_W-1:0]      zone_tag,
    output logic                  zone_last,
    output logic                  zone_valid,
    input  logic                  zone_ready,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    zone_state_t           state_q, state_d;
    logic [ZONE_NUM-1:0]   pend_q, pend_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic [ZONE_ID_W-1:0]  ffs_idx;
    logic                  pend_any;
    logic                  pend_last;
    logic                  busy;
    logic                  beat;
    logic                  accept;

    ffs_encoder #(
        .WIDTH (ZONE_NUM),
        .IDX_W (ZONE_ID_W)
    ) u_ffs (
        .vec_i (pend_q),
        .idx_o (ffs_idx),
        .any_o (pend_any)
    );

    assign busy      = (state_q == ST_BUSY);
    assign pend_last = popcount_is_one(ZONE_MAX_W'(pend_q));
    assign beat      = busy && zone_ready;

    // Refill is allowed on the cycle the final beat of the current mask leaves.
    assign mask_ready = !busy || (beat && pend_last);
    assign accept     = mask_valid && mask_ready;

    assign zone_valid = busy;
    assign zone_id    = pend_any ? ffs_idx : '0;
    assign zone_last  = busy && pend_last;
    assign zone_tag   = tag_q;
    assign drop_cnt   = drop_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        tag_d   = tag_q;
        drop_d  = drop_q;

        if (beat) begin
            pend_d = pend_q & (pend_q - ZONE_NUM'(1));
            if (pend_last) begin
                state_d = ST_EMPTY;
            end
        end

        if (accept) begin
            if (zone_mask != '0) begin
                pend_d  = zone_mask;
                tag_d   = mask_tag;
                state_d = ST_BUSY;
            end else begin
                pend_d  = '0;
                state_d = ST_EMPTY;
                if (drop_q != '1) begin
                    drop_d = drop_q + DROP_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            pend_q  <= '0;
            tag_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_zone_mask_serializer.sv
// Directed bench for zone_mask_serializer: a 16-zone instance for the main
// sequences plus a 2-bit drop counter instance for saturation.
module tb_zone_mask_serializer;

    logic        clk;
    logic        rst_n;

    logic [15:0] zone_mask;
    logic [5:0]  mask_tag;
    logic        mask_valid;
    logic        mask_ready;
    logic [3:0]  zone_id;
    logic [5:0]  zone_tag;
    logic        zone_last;
    logic        zone_valid;
    logic        zone_ready;
    logic [15:0] drop_cnt;

    logic [15:0] s_mask;
    logic [5:0]  s_tag;
    logic        s_mask_valid;
    logic        s_mask_ready;
    logic [3:0]  s_zone_id;
    logic [5:0]  s_zone_tag;
    logic        s_zone_last;
    logic        s_zone_valid;
    logic        s_zone_ready;
    logic [1:0]  s_drop_cnt;

    int checks;
    int errors;

    zone_mask_serializer #(
        .ZONE_NUM   (16),
        .TAG_W      (6),
        .DROP_CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .zone_mask  (zone_mask),
        .mask_tag   (mask_tag),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .zone_id    (zone_id),
        .zone_tag   (zone_tag),
        .zone_last  (zone_last),
        .zone_valid (zone_valid),
        .zone_ready (zone_ready),
        .drop_cnt   (drop_cnt)
    );

    zone_mask_serializer #(
        .ZONE_NUM   (16),
        .TAG_W      (6),
        .DROP_CNT_W (2)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .zone_mask  (s_mask),
        .mask_tag   (s_tag),
        .mask_valid (s_mask_valid),
        .mask_ready (s_mask_ready),
        .zone_id    (s_zone_id),
        .zone_tag   (s_zone_tag),
        .zone_last  (s_zone_last),
        .zone_valid (s_zone_valid),
        .zone_ready (s_zone_ready),
        .drop_cnt   (s_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] id, input logic [5:0] tg,
                            input logic last);
        chk({tag, ".valid"}, 32'(zone_valid), 32'(1'b1));
        chk({tag, ".id"},    32'(zone_id),    32'(id));
        chk({tag, ".tag"},   32'(zone_tag),   32'(tg));
        chk({tag, ".last"},  32'(zone_last),  32'(last));
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        zone_mask    = '0;
        mask_tag     = '0;
        mask_valid   = 1'b0;
        zone_ready   = 1'b1;
        s_mask       = '0;
        s_tag        = '0;
        s_mask_valid = 1'b0;
        s_zone_ready = 1'b1;

        // Reset state
        #12;
        chk("rst.zone_valid", 32'(zone_valid), 32'(1'b0));
        chk("rst.zone_id",    32'(zone_id),    32'(4'd0));
        chk("rst.zone_tag",   32'(zone_tag),   32'(6'd0));
        chk("rst.zone_last",  32'(zone_last),  32'(1'b0));
        chk("rst.drop_cnt",   32'(drop_cnt),   32'(16'd0));
        chk("rst.mask_ready", 32'(mask_ready), 32'(1'b1));
        #5 rst_n = 1'b1;

        // Single mask 0x8421 tag 5
        step();
        zone_mask = 16'h8421; mask_tag = 6'd5; mask_valid = 1'b1;
        #1;
        chk("single.ready_idle", 32'(mask_ready), 32'(1'b1));
        chk("single.idle_valid", 32'(zone_valid), 32'(1'b0));
        step();
        mask_valid = 1'b0; zone_mask = '0; mask_tag = '0;
        #1;
        chk_beat("single.b0", 4'd0, 6'd5, 1'b0);
        chk("single.b0_ready", 32'(mask_ready), 32'(1'b0));
        step(); #1;
        chk_beat("single.b1", 4'd5, 6'd5, 1'b0);
        step(); #1;
        chk_beat("single.b2", 4'd10, 6'd5, 1'b0);
        step(); #1;
        chk_beat("single.b3", 4'd15, 6'd5, 1'b1);
        step(); #1;
        chk("single.done_valid", 32'(zone_valid), 32'(1'b0));

        // Back-to-back 0x0003 then 0x0100
        zone_mask = 16'h0003; mask_tag = 6'd1; mask_valid = 1'b1;
        #1;
        step();
        zone_mask = 16'h0100; mask_tag = 6'd2; mask_valid = 1'b1;
        #1;
        chk_beat("b2b.b0", 4'd0, 6'd1, 1'b0);
        chk("b2b.b0_ready", 32'(mask_ready), 32'(1'b0));
        step(); #1;
        chk_beat("b2b.b1", 4'd1, 6'd1, 1'b1);
        chk("b2b.b1_ready", 32'(mask_ready), 32'(1'b1));
        step();
        mask_valid = 1'b0; zone_mask = '0;
        #1;
        chk_beat("b2b.b2", 4'd8, 6'd2, 1'b1);
        step(); #1;
        chk("b2b.done_valid", 32'(zone_valid), 32'(1'b0));

        // Backpressure on 0x0006
        zone_mask = 16'h0006; mask_tag = 6'd3; mask_valid = 1'b1;
        #1;
        step();
        mask_valid = 1'b0; zone_mask = '0; zone_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                step(); #1;
            end
            chk_beat("bp.hold", 4'd1, 6'd3, 1'b0);
            chk("bp.hold_ready", 32'(mask_ready), 32'(1'b0));
        end
        zone_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(mask_ready), 32'(1'b0));
        step(); #1;
        chk_beat("bp.b1", 4'd2, 6'd3, 1'b1);
        chk("bp.b1_ready", 32'(mask_ready), 32'(1'b1));
        step(); #1;
        chk("bp.done_valid", 32'(zone_valid), 32'(1'b0));

        // Three zero masks then 0x0001
        zone_mask = 16'h0000; mask_tag = 6'd9; mask_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("empty.no_beat", 32'(zone_valid), 32'(1'b0));
            chk("empty.ready", 32'(mask_ready), 32'(1'b1));
            chk("empty.drop_run", 32'(drop_cnt), 32'(i));
            step(); #1;
        end
        zone_mask = 16'h0001; mask_tag = 6'd4;
        #1;
        chk("empty.drop3", 32'(drop_cnt), 32'(16'd3));
        chk("empty.no_beat_after", 32'(zone_valid), 32'(1'b0));
        step();
        mask_valid = 1'b0; zone_mask = '0;
        #1;
        chk_beat("empty.one", 4'd0, 6'd4, 1'b1);
        step(); #1;
        chk("empty.done_valid", 32'(zone_valid), 32'(1'b0));
        chk("empty.drop_hold", 32'(drop_cnt), 32'(16'd3));

        // Saturation on the 2-bit counter instance
        s_mask = 16'h0000; s_mask_valid = 1'b1;
        #1;
        for (int i = 1; i <= 5; i++) begin
            step(); #1;
            chk("sat.drop", 32'(s_drop_cnt), 32'((i > 3) ? 3 : i));
            chk("sat.no_beat", 32'(s_zone_valid), 32'(1'b0));
        end
        s_mask_valid = 1'b0;

        // Zero-mask refill on the last beat of 0x0010
        zone_mask = 16'h0010; mask_tag = 6'd7; mask_valid = 1'b1;
        #1;
        step();
        zone_mask = 16'h0000; mask_tag = 6'd8; mask_valid = 1'b1;
        #1;
        chk_beat("zref.b0", 4'd4, 6'd7, 1'b1);
        chk("zref.b0_ready", 32'(mask_ready), 32'(1'b1));
        step();
        mask_valid = 1'b0;
        #1;
        chk("zref.valid", 32'(zone_valid), 32'(1'b0));
        chk("zref.drop", 32'(drop_cnt), 32'(16'd4));
        chk("zref.ready", 32'(mask_ready), 32'(1'b1));
        step(); #1;
        chk("zref.still_idle", 32'(zone_valid), 32'(1'b0));

        // Asynchronous reset during the second beat of 0x00F0
        zone_mask = 16'h00F0; mask_tag = 6'd6; mask_valid = 1'b1;
        #1;
        step();
        mask_valid = 1'b0; zone_mask = '0;
        #1;
        chk_beat("arst.b0", 4'd4, 6'd6, 1'b0);
        step(); #1;
        chk_beat("arst.b1", 4'd5, 6'd6, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.valid_drop", 32'(zone_valid), 32'(1'b0));
        chk("arst.ready", 32'(mask_ready), 32'(1'b1));
        chk("arst.drop_clr", 32'(drop_cnt), 32'(16'd0));
        #3 rst_n = 1'b1;
        step(); #1;
        chk("arst.post_valid", 32'(zone_valid), 32'(1'b0));
        chk("arst.post_ready", 32'(mask_ready), 32'(1'b1));
        zone_mask = 16'h0002; mask_tag = 6'd2; mask_valid = 1'b1;
        #1;
        step();
        mask_valid = 1'b0; zone_mask = '0;
        #1;
        chk_beat("arst.next", 4'd1, 6'd2, 1'b1);
        step(); #1;
        chk("arst.next_done", 32'(zone_valid), 32'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zone_mask_serializer.md
# zone_mask_serializer

Downstream stage of the zone-ID multicast stage. It accepts one per-library-vector zone mask (`ZONE_NUM` bits, up to 4 bits set) on a valid/ready handshake. It emits the set zones one at a time as binary zone IDs, lowest first, with a last flag, so that per-zone accumulators can be addressed by index. All-zero masks (library vectors with every zone slot left empty) are consumed silently and counted.

## Interface
Parameters:
- `ZONE_NUM`, default `` `CFG_ZONE_NUM ``: number of zones, which is the mask width.
- `ZONE_ID_W`, default `$clog2(ZONE_NUM)` (minimum 1): width of an emitted zone ID.
- `TAG_W`, default `$clog2(`CFG_LIB_VEC_NUM)`: width of the side-band tag (library-vector index) carried with each mask.
- `DROP_CNT_W`, default 16: width of the empty-mask counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `zone_mask` in `ZONE_NUM`: input mask.
- `mask_tag` in `TAG_W`: tag sampled together with the mask.
- `mask_valid` in 1: input mask valid.
- `mask_ready` out 1: block can take a mask this cycle.
- `zone_id` out `ZONE_ID_W`: current zone index.
- `zone_tag` out `TAG_W`: tag of the mask being serialized.
- `zone_last` out 1: this beat is the highest set bit of the mask.
- `zone_valid` out 1: output beat valid.
- `zone_ready` in 1: consumer accepts the beat.
- `drop_cnt` out `DROP_CNT_W`: saturating count of all-zero masks consumed.

## Operation
- One holding register `pend` (`ZONE_NUM` bits), one tag register, and state EMPTY/BUSY.
- A mask is accepted when `mask_valid && mask_ready`.
- `mask_ready` = EMPTY, or (BUSY and `zone_valid && zone_ready && zone_last`). This is the back-to-back refill path.
- On accept of a non-zero mask: `pend <= zone_mask`, tag register loads `mask_tag`, next state BUSY.
- On accept of a zero mask: no output beat; `drop_cnt` increments, saturating at all-ones; state goes to, or stays, EMPTY.
- In BUSY:
  - `zone_valid` = 1.
  - `zone_id` = index of the lowest set bit of `pend`, from a find-first-set.
  - `zone_last` = 1 when `pend` has exactly one bit set.
  - `zone_tag` = tag register.
- On each accepted beat the lowest set bit of `pend` is cleared.
- After the last beat the state returns to EMPTY, unless a refill is accepted in the same cycle. A refill loads the new mask directly, so there is no bubble.
- A zero mask arriving on the refill cycle: the state goes to EMPTY and `drop_cnt` increments.
- While `zone_ready` = 0, all outputs hold stable and `pend` is unchanged (AXI-style stability).
- Mask bits at index ≥ `ZONE_NUM` do not exist. Behaviour for masks with more than 4 bits set is defined: all bits are emitted, in ascending order.

## Timing
- Reset values:
  - `zone_valid` = 0
  - `zone_id` = 0
  - `zone_tag` = 0
  - `zone_last` = 0
  - `drop_cnt` = 0
  - `pend` = 0
  - state EMPTY
  - `mask_ready` = 1 (from EMPTY; it is driven high while `rst_n` is low)
- Latency: a mask accepted at edge N gives its first beat with `zone_valid` = 1 in the cycle after N.
- Throughput: a mask with k set bits occupies k output cycles. With `zone_ready` held at 1, consecutive non-zero masks stream with no idle cycles.
- A zero mask costs 1 input cycle and no output cycles.
- `mask_ready` is combinational from state, `pend` and `zone_ready`. `zone_*` outputs are combinational only from registers.
- Reset asserted mid-mask: the pending beats are discarded immediately and asynchronously, and `zone_valid` drops in the same instant. After release, the block is EMPTY.

## Structure
- Shared package `zone_pkg`:
  - `ZONE_ID_W` derivation function (clog2 with minimum 1).
  - State enum constants `ST_EMPTY` and `ST_BUSY`.
  - A popcount-is-one helper function.
- Sub-module `ffs_encoder` (parameter `WIDTH`): combinational lowest-set-bit index plus any-set flag. It is reused by other zone stages.
- The top level holds the registers, the FSM and the saturating counter.

## Test plan
- Single mask: `ZONE_NUM` = 16, mask 0x8421, tag 5, `zone_ready` = 1. Expect beats with IDs 0, 5, 10, 15 on consecutive cycles, tag 5 on all, `zone_last` only on ID 15.
- Back-to-back: masks 0x0003 then 0x0100 presented continuously. Expect IDs 0, 1, 8 on 3 consecutive cycles. `mask_ready` is high in the cycle of ID 1's last beat, and there is no bubble.
- Backpressure: mask 0x0006 with `zone_ready` low for 4 cycles after the first beat is valid. Expect ID 1 held stable for all 4 cycles and `mask_ready` = 0 throughout, then ID 2 with last.
- Empty masks: 3 zero masks, then 0x0001. Expect no beats for the zeros, `drop_cnt` = 3, then a single beat with ID 0 and last. Also force the counter to saturation (`DROP_CNT_W` = 2, 5 zero masks) and expect `drop_cnt` = 3.
- Refill with a zero mask: a zero mask accepted on the last-beat cycle of mask 0x0010. Expect the state to return to EMPTY, `drop_cnt` +1, and `zone_valid` = 0 on the next cycle.
- Reset mid-operation: assert `rst_n` low, asynchronously, during the second beat of 0x00F0. Expect `zone_valid` = 0 at once. After release, `mask_ready` = 1 and the next mask 0x0002 yields a single beat with ID 1.
